// File: rtl/cache_write_buffer_pkg.sv
// Shared types for the cache posted-write buffer.
package cache_wb_pkg;

  localparam int WORD_LSB  = 2;
  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;

  typedef enum logic [1:0] {WB_IDLE, WB_FLUSH, WB_DONE} wb_state_t;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
    logic                 evict;
  } wb_entry_t;

endpackage

// File: rtl/cache_write_buffer_if.sv
// Store-in and memory-out handshake channels of the write buffer.
interface cache_write_buffer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic              in_evict;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_evict;

  // cache + memory side (drives stores, accepts drains)
  modport master (
    output in_valid, in_addr, in_data, in_evict, mem_ready,
    input  in_ready, mem_valid, mem_addr, mem_data, mem_evict
  );

  // buffer side
  modport slave (
    input  in_valid, in_addr, in_data, in_evict, mem_ready,
    output in_ready, mem_valid, mem_addr, mem_data, mem_evict
  );
endinterface

// File: rtl/cache_write_buffer_fwd.sv
// Store-to-load forwarding match: youngest valid entry whose word address
// equals the lookup wins. Age is measured from tail (oldest slot) upward.
module wb_fwd_match #(
  parameter int DEPTH  = 4,
  parameter int AW     = 30,
  parameter int DATA_W = 32
) (
  input  logic [DEPTH-1:0]             i_vld,
  input  logic [DEPTH-1:0][AW-1:0]     i_addr,
  input  logic [DEPTH-1:0][DATA_W-1:0] i_data,
  input  logic [$clog2(DEPTH)-1:0]     i_tail,
  input  logic [AW-1:0]                i_lookup,
  output logic                         o_hit,
  output logic [DATA_W-1:0]            o_data
);
  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0] w_match;

  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    assign w_match[i] = i_vld[i] && (i_addr[i] == i_lookup);
  end

  // Walk oldest -> youngest so the last match seen is the youngest one.
  always_comb begin
    logic [PW-1:0] v_idx;
    v_idx  = '0;
    o_hit  = 1'b0;
    o_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      v_idx = i_tail + PW'(k);
      if (w_match[v_idx]) begin
        o_hit  = 1'b1;
        o_data = i_data[v_idx];
      end
    end
  end
endmodule

// File: rtl/cache_write_buffer.sv
// Posted-write FIFO between the cache and main memory with a flush
// sequence. Optional store-to-load forwarding under macro WB_FORWARD_EN.
module cache_write_buffer
  import cache_wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DATA_W = WB_DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  cache_write_buffer_if.slave      bus,
  input  logic                     flush_req,
  output logic                     flush_done,
  input  logic [ADDR_W-1:0]        lookup_addr,
  output logic                     lookup_hit,
  output logic [DATA_W-1:0]        lookup_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int PW = $clog2(DEPTH);

  wb_entry_t      r_ent [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [PW-1:0]  r_head, r_tail;
  logic [PW:0]    r_count;
  wb_state_t      r_state;
  logic           r_done;

  logic           w_push, w_pop;
  logic [PW:0]    w_count_nxt;

  assign w_push      = bus.in_valid && bus.in_ready;
  assign w_pop       = bus.mem_valid && bus.mem_ready;
  assign w_count_nxt = r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);

  assign count      = r_count;
  assign empty      = (r_count == '0);
  assign full       = (r_count == (PW+1)'(DEPTH));
  assign flush_done = r_done;

  // No full-bypass: a pop this cycle does not open the input.
  assign bus.in_ready  = !full && (r_state == WB_IDLE);
  assign bus.mem_valid = !empty;
  assign bus.mem_addr  = r_ent[r_head].addr;
  assign bus.mem_data  = r_ent[r_head].data;
  assign bus.mem_evict = r_ent[r_head].evict;

  // Entry payload; validity lives in r_vld so no reset is needed here.
  always_ff @(posedge clk) begin
    if (w_push) r_ent[r_tail] <= '{addr: bus.in_addr, data: bus.in_data, evict: bus.in_evict};
  end

  // Pointers, occupancy and per-entry valid bits.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_vld   <= '0;
    end else begin
      if (w_push) begin
        r_tail        <= r_tail + PW'(1);
        r_vld[r_tail] <= 1'b1;
      end
      if (w_pop) begin
        r_head        <= r_head + PW'(1);
        r_vld[r_head] <= 1'b0;
      end
      r_count <= w_count_nxt;
    end
  end

  // Flush FSM: close the input, drain, then pulse flush_done once.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= WB_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        WB_IDLE:  if (flush_req) r_state <= WB_FLUSH;
        WB_FLUSH: if (w_count_nxt == '0) begin
                    r_state <= WB_DONE;
                    r_done  <= 1'b1;
                  end
        default:  r_state <= WB_IDLE;
      endcase
    end
  end

`ifdef WB_FORWARD_EN
  logic [DEPTH-1:0][ADDR_W-WORD_LSB-1:0] w_waddr;
  logic [DEPTH-1:0][DATA_W-1:0]          w_wdata;
  logic                                  w_unused_lsb;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign w_waddr[i] = r_ent[i].addr[ADDR_W-1:WORD_LSB];
    assign w_wdata[i] = r_ent[i].data;
  end

  // Word-granular compare: byte offset bits are ignored.
  assign w_unused_lsb = ^lookup_addr[WORD_LSB-1:0];

  wb_fwd_match #(
    .DEPTH  (DEPTH),
    .AW     (ADDR_W-WORD_LSB),
    .DATA_W (DATA_W)
  ) u_fwd (
    .i_vld    (r_vld),
    .i_addr   (w_waddr),
    .i_data   (w_wdata),
    .i_tail   (r_tail),
    .i_lookup (lookup_addr[ADDR_W-1:WORD_LSB]),
    .o_hit    (lookup_hit),
    .o_data   (lookup_data)
  );
`else
  logic w_unused_fwd;

  // Without forwarding the cache must flush before reading these regions.
  assign w_unused_fwd = ^{lookup_addr, r_vld};
  assign lookup_hit   = 1'b0;
  assign lookup_data  = '0;
`endif

endmodule
